// File: rtl/tlc_pkg.sv
// Shared types and width helpers for the multi-way traffic light controller.
package tlc_pkg;

    typedef enum logic [1:0] {
        ST_GREEN  = 2'd0,
        ST_YELLOW = 2'd1,
        ST_ALLRED = 2'd2
    } tlc_state_e;

    function automatic int tlc_clog2(input int v);
        int r;
        r = 0;
        for (int unsigned i = 0; i < 31; i++) begin
            if ((32'd1 << i) < v) r = int'(i) + 1;
        end
        return r;
    endfunction

    function automatic int tlc_idx_w(input int n);
        return (n <= 2) ? 1 : tlc_clog2(n);
    endfunction

    function automatic int tlc_timer_w(input int gmax, input int yt, input int at);
        int m;
        m = gmax;
        if (yt > m) m = yt;
        if (at > m) m = at;
        return tlc_clog2(m + 1);
    endfunction

endpackage

// File: rtl/tlc_rr_pick.sv
// Combinational round-robin picker: first set request at or after i_start, wrapping.
module tlc_rr_pick
    import tlc_pkg::*;
#(
    parameter int N_DIR = 2,
    localparam int IDX_W = tlc_idx_w(N_DIR)
) (
    input  logic [N_DIR-1:0] i_req,
    input  logic [IDX_W-1:0] i_start,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    int unsigned w_pos;

    always_comb begin
        o_idx   = '0;
        o_valid = 1'b0;
        w_pos   = 0;
        for (int unsigned k = 0; k < N_DIR; k++) begin
            w_pos = (32'(i_start) + k) % N_DIR;
            if (!o_valid && (((i_req >> w_pos) & N_DIR'(1)) != '0)) begin
                o_valid = 1'b1;
                o_idx   = IDX_W'(w_pos);
            end
        end
    end

endmodule

// File: rtl/tlc_multiway.sv
// N-way sensor-driven traffic light controller with min/max green, yellow and all-red.
// Optional emergency preemption is enabled by defining TLC_PREEMPT_EN.
module tlc_multiway
    import tlc_pkg::*;
#(
    parameter int N_DIR     = 2,
    parameter int GREEN_MIN = 5,
    parameter int GREEN_MAX = 15,
    parameter int YELLOW_T  = 2,
    parameter int ALLRED_T  = 1,
    localparam int IDX_W    = tlc_idx_w(N_DIR)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_DIR-1:0] sense_i,
    output logic [N_DIR-1:0] green_o,
    output logic [N_DIR-1:0] yellow_o,
    output logic [N_DIR-1:0] red_o,
    output logic [IDX_W-1:0] active_o
`ifdef TLC_PREEMPT_EN
    ,
    input  logic             preempt_i,
    input  logic [IDX_W-1:0] preempt_dir_i
`endif
);

    localparam int TW = tlc_timer_w(GREEN_MAX, YELLOW_T, ALLRED_T);

    tlc_state_e       r_state;
    logic [IDX_W-1:0] r_active;
    logic [IDX_W-1:0] r_next;
    logic [TW-1:0]    r_timer;
    logic [N_DIR-1:0] r_green, r_yellow, r_red;

    tlc_state_e       w_n_state;
    logic [IDX_W-1:0] w_n_active, w_n_next, w_start, w_pick;
    logic [TW-1:0]    w_n_timer, w_timer_sat;
    logic [N_DIR-1:0] w_act_oh, w_other, w_n_green, w_n_yellow, w_n_red;
    logic             w_own, w_pick_v, w_exit;

    assign w_act_oh    = N_DIR'(1) << r_active;
    assign w_other     = sense_i & ~w_act_oh;
    assign w_own       = |(sense_i & w_act_oh);
    assign w_start     = (r_active == IDX_W'(N_DIR - 1)) ? '0 : r_active + IDX_W'(1);
    assign w_timer_sat = (r_timer >= TW'(GREEN_MAX - 1)) ? r_timer : r_timer + TW'(1);
    assign w_exit      = (r_timer >= TW'(GREEN_MIN - 1)) && w_pick_v &&
                         (!w_own || (r_timer >= TW'(GREEN_MAX - 1)));

`ifdef TLC_PREEMPT_EN
    logic w_pv;
    assign w_pv = preempt_i && (32'(preempt_dir_i) < 32'(N_DIR));
`endif

    tlc_rr_pick #(.N_DIR(N_DIR)) u_pick (
        .i_req   (w_other),
        .i_start (w_start),
        .o_idx   (w_pick),
        .o_valid (w_pick_v)
    );

    always_comb begin
        w_n_state  = r_state;
        w_n_active = r_active;
        w_n_next   = r_next;
        w_n_timer  = r_timer;
        unique case (r_state)
            ST_GREEN: begin
`ifdef TLC_PREEMPT_EN
                // Preempt to another approach bypasses GREEN_MIN; to ourselves it pins green.
                if (w_pv && (preempt_dir_i != r_active)) begin
                    w_n_state = ST_YELLOW;
                    w_n_timer = '0;
                    w_n_next  = preempt_dir_i;
                end else if (w_pv) begin
                    w_n_timer = w_timer_sat;
                end else
`endif
                if (w_exit) begin
                    w_n_state = ST_YELLOW;
                    w_n_timer = '0;
                    w_n_next  = w_pick;
                end else begin
                    w_n_timer = w_timer_sat;
                end
            end
            ST_YELLOW: begin
`ifdef TLC_PREEMPT_EN
                if (w_pv) w_n_next = preempt_dir_i;
`endif
                if (r_timer == TW'(YELLOW_T - 1)) begin
                    w_n_state = ST_ALLRED;
                    w_n_timer = '0;
                end else begin
                    w_n_timer = r_timer + TW'(1);
                end
            end
            ST_ALLRED: begin
`ifdef TLC_PREEMPT_EN
                if (w_pv) w_n_next = preempt_dir_i;
`endif
                if (r_timer == TW'(ALLRED_T - 1)) begin
                    w_n_state  = ST_GREEN;
                    w_n_active = w_n_next;
                    w_n_timer  = '0;
                end else begin
                    w_n_timer = r_timer + TW'(1);
                end
            end
            default: begin
                w_n_state  = ST_GREEN;
                w_n_active = '0;
                w_n_next   = '0;
                w_n_timer  = '0;
            end
        endcase

        // Lamps are registered from the next state so outputs never see sense_i directly.
        w_n_green  = (w_n_state == ST_GREEN)  ? (N_DIR'(1) << w_n_active) : '0;
        w_n_yellow = (w_n_state == ST_YELLOW) ? (N_DIR'(1) << w_n_active) : '0;
        w_n_red    = ~(w_n_green | w_n_yellow);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_GREEN;
            r_active <= '0;
            r_next   <= '0;
            r_timer  <= '0;
            r_green  <= N_DIR'(1);
            r_yellow <= '0;
            r_red    <= ~N_DIR'(1);
        end else begin
            r_state  <= w_n_state;
            r_active <= w_n_active;
            r_next   <= w_n_next;
            r_timer  <= w_n_timer;
            r_green  <= w_n_green;
            r_yellow <= w_n_yellow;
            r_red    <= w_n_red;
        end
    end

    assign green_o  = r_green;
    assign yellow_o = r_yellow;
    assign red_o    = r_red;
    assign active_o = r_active;

endmodule

// File: tb/tb_tlc_multiway.sv
// Self-checking bench for tlc_multiway (N_DIR=4) against a phase/dwell reference model.
module tb_tlc_multiway;

    localparam int N    = 4;
    localparam int GMIN = 4;
    localparam int GMAX = 8;
    localparam int YT   = 2;
    localparam int AT   = 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] sense_i = '0;
    logic [3:0] green_o, yellow_o, red_o;
    logic [1:0] active_o;
`ifdef TLC_PREEMPT_EN
    logic       preempt_i = 1'b0;
    logic [1:0] preempt_dir_i = '0;
`endif

    tlc_multiway #(
        .N_DIR     (N),
        .GREEN_MIN (GMIN),
        .GREEN_MAX (GMAX),
        .YELLOW_T  (YT),
        .ALLRED_T  (AT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sense_i  (sense_i),
        .green_o  (green_o),
        .yellow_o (yellow_o),
        .red_o    (red_o),
        .active_o (active_o)
`ifdef TLC_PREEMPT_EN
        ,
        .preempt_i     (preempt_i),
        .preempt_dir_i (preempt_dir_i)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: phase 0=green 1=yellow 2=allred, el = cycles already spent in phase.
    int m_phase, m_act, m_el, m_next;

    function automatic logic [13:0] m_lamps();
        logic [3:0] g, y;
        g = (m_phase == 0) ? (4'b0001 << m_act) : 4'b0000;
        y = (m_phase == 1) ? (4'b0001 << m_act) : 4'b0000;
        return {g, y, ~(g | y), 2'(m_act)};
    endfunction

    function automatic int m_rr(input logic [3:0] req, input int from);
        for (int d = 1; d <= N; d++) begin
            if (req[(from + d) % N]) return (from + d) % N;
        end
        return from;
    endfunction

    task automatic m_reset();
        m_phase = 0; m_act = 0; m_el = 0; m_next = 0;
    endtask

    task automatic m_step(input logic [3:0] s, input logic p, input int pd);
        logic [3:0] others;
        others = s & ~(4'b0001 << m_act);
        case (m_phase)
            0: begin
                if (p && pd != m_act) begin
                    m_phase = 1; m_el = 0; m_next = pd;
                end else if (!p && others != 0 && m_el >= GMIN - 1 &&
                             (!s[m_act] || m_el >= GMAX - 1)) begin
                    m_phase = 1; m_el = 0; m_next = m_rr(others, m_act);
                end else begin
                    m_el++;
                end
            end
            1: begin
                if (p) m_next = pd;
                if (m_el + 1 == YT) begin m_phase = 2; m_el = 0; end
                else m_el++;
            end
            default: begin
                if (p) m_next = pd;
                if (m_el + 1 == AT) begin m_phase = 0; m_act = m_next; m_el = 0; end
                else m_el++;
            end
        endcase
    endtask

    // Drive one clock with the given inputs, advance the model, and land #1 after the edge.
    task automatic tick(input logic [3:0] s, input logic p, input int pd, input logic rst);
        sense_i = s;
        rst_n   = ~rst;
`ifdef TLC_PREEMPT_EN
        preempt_i     = p;
        preempt_dir_i = 2'(pd);
`endif
        @(posedge clk);
        if (rst) m_reset();
        else m_step(s, p, pd);
        #1;
    endtask

    function automatic logic [13:0] obs();
        return {green_o, yellow_o, red_o, active_o};
    endfunction

    task automatic test_reset();
        tick(4'b0000, 1'b0, 0, 1'b1);
        tick(4'b1111, 1'b0, 0, 1'b1);
        checks++;
        if (green_o !== 4'b0001) begin errors++; $display("FAIL reset_green got=%b exp=0001", green_o); end
        checks++;
        if (yellow_o !== 4'b0000) begin errors++; $display("FAIL reset_yellow got=%b exp=0000", yellow_o); end
        checks++;
        if (red_o !== 4'b1110) begin errors++; $display("FAIL reset_red got=%b exp=1110", red_o); end
        checks++;
        if (active_o !== 2'd0) begin errors++; $display("FAIL reset_active got=%0d exp=0", active_o); end
    endtask

    task automatic test_idle();
        tick(4'b0000, 1'b0, 0, 1'b1);
        for (int i = 0; i < 50; i++) begin
            tick(4'b0000, 1'b0, 0, 1'b0);
            checks++;
            if (obs() !== {4'b0001, 4'b0000, 4'b1110, 2'd0}) begin
                errors++;
                $display("FAIL idle_hold cyc=%0d got=%h exp=%h", i, obs(), {4'b0001, 4'b0000, 4'b1110, 2'd0});
            end
        end
    endtask

    task automatic test_single();
        logic [13:0] tab [8];
        for (int i = 0; i < 4; i++) tab[i] = {4'b0001, 4'b0000, 4'b1110, 2'd0};
        tab[4] = {4'b0000, 4'b0001, 4'b1110, 2'd0};
        tab[5] = {4'b0000, 4'b0001, 4'b1110, 2'd0};
        tab[6] = {4'b0000, 4'b0000, 4'b1111, 2'd0};
        tab[7] = {4'b0100, 4'b0000, 4'b1011, 2'd2};
        tick(4'b0100, 1'b0, 0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) tick(4'b0100, 1'b0, 0, 1'b0);
            checks++;
            if (obs() !== tab[i]) begin
                errors++;
                $display("FAIL single_seq step=%0d got=%h exp=%h", i, obs(), tab[i]);
            end
        end
    endtask

    task automatic test_all_request();
        int starts[$];
        int lens[$];
        int exp_seq[5] = '{0, 1, 2, 3, 0};
        bit in_green;
        in_green = 1'b0;
        tick(4'b1111, 1'b0, 0, 1'b1);
        for (int i = 0; i < 60; i++) begin
            if (i > 0) tick(4'b1111, 1'b0, 0, 1'b0);
            checks++;
            if (obs() !== m_lamps()) begin
                errors++;
                $display("FAIL all_req_model cyc=%0d got=%h exp=%h", i, obs(), m_lamps());
            end
            if (green_o != 4'b0000) begin
                if (!in_green) begin starts.push_back(int'(active_o)); lens.push_back(0); end
                lens[lens.size() - 1]++;
                in_green = 1'b1;
            end else begin
                in_green = 1'b0;
            end
        end
        checks++;
        if (starts.size() < 5) begin
            errors++;
            $display("FAIL all_req_count got=%0d exp>=5", starts.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                checks++;
                if (starts[k] != exp_seq[k]) begin
                    errors++;
                    $display("FAIL all_req_order idx=%0d got=%0d exp=%0d", k, starts[k], exp_seq[k]);
                end
            end
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (lens[k] != GMAX) begin
                    errors++;
                    $display("FAIL all_req_len idx=%0d got=%0d exp=%0d", k, lens[k], GMAX);
                end
            end
        end
    endtask

    task automatic test_round_robin();
        int n;
        tick(4'b0010, 1'b0, 0, 1'b1);
        for (int i = 0; i < 7; i++) tick(4'b0010, 1'b0, 0, 1'b0);
        checks++;
        if (active_o !== 2'd1 || green_o !== 4'b0010) begin
            errors++;
            $display("FAIL rr_setup got act=%0d green=%b exp act=1 green=0010", active_o, green_o);
        end
        n = 0;
        while (active_o == 2'd1 && n < 30) begin
            tick(4'b1001, 1'b0, 0, 1'b0);
            n++;
            checks++;
            if (obs() !== m_lamps()) begin
                errors++;
                $display("FAIL rr_model cyc=%0d got=%h exp=%h", n, obs(), m_lamps());
            end
        end
        checks++;
        if (active_o !== 2'd3 || green_o !== 4'b1000) begin
            errors++;
            $display("FAIL rr_next got act=%0d green=%b exp act=3 green=1000", active_o, green_o);
        end
    endtask

    task automatic test_reset_in_yellow();
        tick(4'b0100, 1'b0, 0, 1'b1);
        for (int i = 0; i < 4; i++) tick(4'b0100, 1'b0, 0, 1'b0);
        checks++;
        if (yellow_o !== 4'b0001) begin
            errors++;
            $display("FAIL ry_yellow got=%b exp=0001", yellow_o);
        end
        tick(4'b0100, 1'b0, 0, 1'b1);
        checks++;
        if (green_o !== 4'b0001 || active_o !== 2'd0 || yellow_o !== 4'b0000) begin
            errors++;
            $display("FAIL ry_reset got g=%b y=%b act=%0d exp g=0001 y=0000 act=0", green_o, yellow_o, active_o);
        end
        for (int i = 0; i < 3; i++) tick(4'b0010, 1'b0, 0, 1'b0);
        checks++;
        if (green_o !== 4'b0001) begin
            errors++;
            $display("FAIL ry_timer_clear got green=%b exp=0001", green_o);
        end
        tick(4'b0010, 1'b0, 0, 1'b0);
        checks++;
        if (yellow_o !== 4'b0001) begin
            errors++;
            $display("FAIL ry_timer_exit got yellow=%b exp=0001", yellow_o);
        end
    endtask

    task automatic test_random();
        logic [3:0] s;
        int hold;
        logic rst;
        s = '0;
        hold = 0;
        tick(4'b0000, 1'b0, 0, 1'b1);
        for (int i = 0; i < 400; i++) begin
            if (hold == 0) begin
                s = 4'($urandom_range(0, 15));
                hold = $urandom_range(1, 12);
            end
            hold--;
            rst = ($urandom_range(0, 63) == 0);
            tick(s, 1'b0, 0, rst);
            checks++;
            if (obs() !== m_lamps()) begin
                errors++;
                $display("FAIL random cyc=%0d sense=%b got=%h exp=%h", i, s, obs(), m_lamps());
            end
        end
    endtask

`ifdef TLC_PREEMPT_EN
    task automatic test_preempt();
        tick(4'b0000, 1'b0, 0, 1'b1);
        tick(4'b0000, 1'b0, 0, 1'b0);
        tick(4'b0000, 1'b1, 2, 1'b0);
        checks++;
        if (yellow_o !== 4'b0001) begin
            errors++;
            $display("FAIL pre_yellow got=%b exp=0001", yellow_o);
        end
        for (int i = 0; i < 20; i++) begin
            tick(4'b1111, 1'b1, 2, 1'b0);
            checks++;
            if (obs() !== m_lamps()) begin
                errors++;
                $display("FAIL pre_model cyc=%0d got=%h exp=%h", i, obs(), m_lamps());
            end
        end
        checks++;
        if (green_o !== 4'b0100 || active_o !== 2'd2) begin
            errors++;
            $display("FAIL pre_hold got green=%b act=%0d exp green=0100 act=2", green_o, active_o);
        end
        for (int i = 0; i < 100; i++) begin
            logic p;
            int pd;
            p  = ($urandom_range(0, 9) == 0);
            pd = $urandom_range(0, 3);
            tick(4'($urandom_range(0, 15)), p, pd, 1'b0);
            checks++;
            if (obs() !== m_lamps()) begin
                errors++;
                $display("FAIL pre_random cyc=%0d got=%h exp=%h", i, obs(), m_lamps());
            end
        end
    endtask
`endif

    initial begin
        m_reset();
        test_reset();
        test_idle();
        test_single();
        test_all_request();
        test_round_robin();
        test_reset_in_yellow();
        test_random();
`ifdef TLC_PREEMPT_EN
        test_preempt();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
